fifo_wr_arbiter: RTL

//  Shares the single write port of one fifo instance between NUM_REQ producers.

---
 rtl/fifo_wr_arbiter_pkg.sv | 10 +
 rtl/fifo_wr_arbiter_picker.sv | 39 +++
 rtl/fifo_wr_arbiter.sv | 99 +++++++++
 3 files changed

// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared definitions for the fifo write-port arbiter family.
package fifo_wr_arbiter_pkg;

    // Arbiter control states: waiting to arbitrate, or forwarding a grantee's burst.
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_e;

endpackage

// File: rtl/fifo_wr_arbiter_picker.sv
// Round-robin priority picker: finds the first set request bit searching
// circularly from the position just after last_i.
module rr_priority_picker
    import fifo_wr_arbiter_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int GW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [GW-1:0]      last_i,
    output logic               found_o,
    output logic [GW-1:0]      idx_o
);

    logic [2*NUM_REQ-1:0] dbl;
    logic [2*NUM_REQ-1:0] masked;

    // Duplicate the request vector, mask everything at or below last_i in the
    // low copy, then take the lowest surviving bit; the upper copy supplies the
    // wrap-around candidates.
    always_comb begin
        dbl     = {req_i, req_i};
        masked  = dbl;
        found_o = 1'b0;
        idx_o   = '0;
        for (int k = 0; k < 2*NUM_REQ; k++) begin
            if (k <= int'(last_i)) begin
                masked[k] = 1'b0;
            end
        end
        for (int k = 2*NUM_REQ-1; k >= 0; k--) begin
            if (masked[k]) begin
                found_o = 1'b1;
                idx_o   = GW'(k % NUM_REQ);
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one fifo write port between NUM_REQ producers,
// granting one producer at a time for a burst of up to MAX_BURST beats.
module fifo_wr_arbiter
    import fifo_wr_arbiter_pkg::*;
#(
    parameter  int NUM_REQ    = 4,
    parameter  int DATA_WIDTH = 32,
    parameter  int MAX_BURST  = 8,
    localparam int GW         = $clog2(NUM_REQ),
    localparam int CW         = $clog2(MAX_BURST+1)
) (
    input  logic                          clk_i,
    input  logic                          rstn_i,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    input  logic [NUM_REQ-1:0]            req_last_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    output logic [DATA_WIDTH-1:0]         fifo_data_o,
    output logic                          fifo_wr_en_o,
    input  logic                          fifo_full_i,
    output logic [GW-1:0]                 grant_id_o,
    output logic                          busy_o
);

    localparam logic [GW-1:0] LAST_RST = GW'(NUM_REQ-1);
    localparam logic [CW-1:0] CNT_CAP  = CW'(MAX_BURST-1);

    state_e          state_q, state_d;
    logic [GW-1:0]   grant_q, grant_d;
    logic [GW-1:0]   last_q,  last_d;
    logic [CW-1:0]   cnt_q,   cnt_d;
    logic            pick_found;
    logic [GW-1:0]   pick_idx;
    logic [NUM_REQ-1:0] grant_oh;

    rr_priority_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_picker (
        .req_i   (req_valid_i),
        .last_i  (last_q),
        .found_o (pick_found),
        .idx_o   (pick_idx)
    );

    assign grant_oh    = NUM_REQ'(1) << grant_q;
    assign fifo_data_o = req_data_i[int'(grant_q)*DATA_WIDTH +: DATA_WIDTH];
    assign grant_id_o  = grant_q;
    assign busy_o      = (state_q == ST_BURST);

    // Next-state and handshake outputs: arbitrate in IDLE, pass the grantee's
    // beats straight through to the fifo in BURST unless the fifo is full.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_d       = last_q;
        cnt_d        = cnt_q;
        req_ready_o  = '0;
        fifo_wr_en_o = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    grant_d = pick_idx;
                    cnt_d   = '0;
                    state_d = ST_BURST;
                end
            end
            ST_BURST: begin
                req_ready_o  = grant_oh & {NUM_REQ{!fifo_full_i}};
                fifo_wr_en_o = req_valid_i[grant_q] & !fifo_full_i;
                if (fifo_wr_en_o) begin
                    cnt_d = cnt_q + CW'(1);
                    if (req_last_i[grant_q] || (cnt_q == CNT_CAP)) begin
                        last_d  = grant_q;
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, grant, round-robin pointer and beat counter registers.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            last_q  <= LAST_RST;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule
